seg7_bcd_display: RTL and testbench
===================================

SEG7_BCD_DISPLAY -- requirements
Module: seg7_bcd_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 100000; clock cycles each digit is driven before the scan advances (legal range 2..2^20).
REQ-002 SHALL have parameter BLANK_LZ, default 1; 1 blanks leading-zero digits, 0 shows all eight digits.
REQ-003 SHALL use one clock; reset is asynchronous and active-high (ports clk and rst).
REQ-004 clk  input  1  system clock, all state on rising edge.
REQ-005 rst  input  1  asynchronous active-high reset.
REQ-006 load  input  1  one-cycle strobe requesting conversion of value.
REQ-007 value  input  16  unsigned binary word to display (CPU LED/IO write data).
REQ-008 busy  output  1  high while a conversion is in progress.
REQ-009 done  output  1  one-cycle pulse when a new BCD result is committed.
REQ-010 bcd_out  output  20  committed BCD result, digit 0 in [3:0] through digit 4 in [19:16].
REQ-011 seg_en  output  8  active-low digit enables, one-hot-low, bit i = digit i (digit 0 rightmost).
REQ-012 seg_out  output  8  active-low segments {dp,g,f,e,d,c,b,a}.

Function
REQ-013 SHALL implement a two-state FSM, IDLE and CONV.
REQ-014 IDLE: load=1 at a clock edge SHALL capture value into a 36-bit shift register {20'b0,value}, clear a 5-bit iteration counter, and enter CONV.
REQ-015 CONV: each cycle SHALL add 3 to every BCD nibble >= 5, then shift the register left by one, and increment the counter.
REQ-016 After the 16th CONV cycle the FSM SHALL return to IDLE, write the BCD nibbles to bcd_out, and pulse done for exactly one cycle.
REQ-017 Latency: load sampled at edge N -> busy=1 for cycles N+1..N+16; bcd_out updated and done=1 in cycle N+17; busy=0 in cycle N+17.
REQ-018 busy SHALL equal (state==CONV).
REQ-019 load asserted while busy SHALL be ignored (not queued); load in the same cycle done is high SHALL be accepted.
REQ-020 bcd_out SHALL hold its previous value throughout a conversion (no partial results visible).
REQ-021 Maximum input 65535 SHALL yield bcd_out = 20'h65535; digits 5..7 are always value 0.
REQ-022 Scan prescaler SHALL count 0..SCAN_DIV-1 continuously, independent of load/busy; on wrap the 3-bit digit index SHALL increment, wrapping 7->0.
REQ-023 seg_en SHALL be ~(8'b1 << index); exactly one bit low at all times after reset.
REQ-024 Segment code for digits 0..9 (hex, dp off): C0,F9,A4,B0,99,92,82,F8,80,90; blank = FF; dp bit SHALL always be 1.
REQ-025 With BLANK_LZ=1, digit i>0 SHALL output FF when all digits >= i are zero; digit 0 SHALL never be blanked.
REQ-026 seg_out SHALL be registered from the same index as seg_en so both change on the same edge (no ghosting).

Reset
REQ-027 rst=1 SHALL asynchronously force: state IDLE, busy=0, done=0, bcd_out=0, shift register and counter 0, prescaler 0, index 0, seg_en=8'hFE, seg_out=8'hC0.
REQ-028 rst during CONV SHALL abort the conversion; no done pulse, bcd_out=0 after reset.
REQ-029 After rst falls, the first load SHALL be accepted on the first clock edge where it is high.

Verification
REQ-030 Reset then load value=16'd12345 -> busy high 16 cycles, then bcd_out=20'h12345, done one cycle; digits 0..4 show 5,4,3,2,1 (92,99,B0,A4,F9), digits 5..7 FF.
REQ-031 load value=16'd65535, then value=16'd0 -> bcd_out 20'h65535, then 20'h00000; second result shows C0 on digit 0, FF on digits 1..7 (BLANK_LZ=1), all C0 with BLANK_LZ=0.
REQ-032 load value=100, pulse load value=7 at busy cycle 5 -> only one done, bcd_out=20'h00100; new load after done converts 7.
REQ-033 load value=999, assert rst at busy cycle 8 -> no done, bcd_out=0, seg_en=FE, seg_out=C0 immediately.
REQ-034 SCAN_DIV=4, no loads -> seg_en steps FE,FD,FB,...,7F,FE every 4 cycles; seg_en and seg_out change on the same edge.
REQ-035 Back-to-back load on the done cycle (value 42 then 4321) -> done twice, 17 cycles apart, final bcd_out=20'h04321.

Source files
------------

// File: rtl/seg7_bcd_display.sv
// Binary-to-BCD converter (serial double-dabble, 16 iterations) feeding an
// eight-digit multiplexed active-low seven-segment display with optional
// leading-zero blanking.
module seg7_bcd_display #(
    parameter int unsigned SCAN_DIV = 100000,
    parameter bit          BLANK_LZ = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [19:0] bcd_out,
    output logic [7:0]  seg_en,
    output logic [7:0]  seg_out
);

    localparam int unsigned PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    typedef enum logic {
        IDLE = 1'b0,
        CONV = 1'b1
    } state_t;

    state_t         state_q;
    logic [35:0]    sr_q;
    logic [35:0]    sr_d;
    logic [4:0]     cnt_q;
    logic [19:0]    bcd_q;
    logic           done_q;

    logic [PW-1:0]  pre_q;
    logic [PW-1:0]  pre_d;
    logic [2:0]     idx_q;
    logic [2:0]     idx_d;
    logic [7:0]     seg_en_q;
    logic [7:0]     seg_out_q;
    logic [7:0]     seg_d;

    assign busy    = (state_q == CONV);
    assign done    = done_q;
    assign bcd_out = bcd_q;
    assign seg_en  = seg_en_q;
    assign seg_out = seg_out_q;

    function automatic logic [7:0] seg_code(input logic [3:0] d);
        logic [7:0] c;
        case (d)
            4'd0:    c = 8'hC0;
            4'd1:    c = 8'hF9;
            4'd2:    c = 8'hA4;
            4'd3:    c = 8'hB0;
            4'd4:    c = 8'h99;
            4'd5:    c = 8'h92;
            4'd6:    c = 8'h82;
            4'd7:    c = 8'hF8;
            4'd8:    c = 8'h80;
            4'd9:    c = 8'h90;
            default: c = 8'hFF;
        endcase
        return c;
    endfunction

    // One double-dabble step: add 3 to every BCD nibble >= 5, then shift left.
    always_comb begin
        logic [35:0] adj;
        adj = sr_q;
        for (int unsigned i = 0; i < 5; i++) begin
            if (sr_q[16 + 4*i +: 4] >= 4'd5) begin
                adj[16 + 4*i +: 4] = sr_q[16 + 4*i +: 4] + 4'd3;
            end
        end
        sr_d = {adj[34:0], 1'b0};
    end

    // Conversion FSM; bcd_out only changes when the final step commits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (load) begin
                        sr_q    <= {20'b0, value};
                        cnt_q   <= '0;
                        state_q <= CONV;
                    end
                end
                CONV: begin
                    sr_q  <= sr_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd15) begin
                        state_q <= IDLE;
                        bcd_q   <= sr_d[35:16];
                        done_q  <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // Scan prescaler / digit index next state and the segment pattern for the
    // digit that will be enabled after the next edge.
    always_comb begin
        logic [31:0] dig_v;
        logic [7:0]  blank_v;
        logic        nz_above;
        if (pre_q == PW'(SCAN_DIV - 1)) begin
            pre_d = '0;
            idx_d = idx_q + 3'd1;
        end else begin
            pre_d = pre_q + {{(PW-1){1'b0}}, 1'b1};
            idx_d = idx_q;
        end
        dig_v    = {12'b0, bcd_q};
        blank_v  = '0;
        nz_above = 1'b0;
        // Scan from the top digit down; a digit blanks while nothing at or
        // above it is non-zero. Digit 0 is never considered.
        for (int unsigned k = 0; k < 7; k++) begin
            nz_above       = nz_above | (dig_v[4*(7-k) +: 4] != 4'd0);
            blank_v[7-k]   = BLANK_LZ && !nz_above;
        end
        seg_d = blank_v[idx_d] ? 8'hFF : seg_code(dig_v[{idx_d, 2'b00} +: 4]);
    end

    // Display scan: enable and segment registers load from the same index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q     <= '0;
            idx_q     <= '0;
            seg_en_q  <= 8'hFE;
            seg_out_q <= 8'hC0;
        end else begin
            pre_q     <= pre_d;
            idx_q     <= idx_d;
            seg_en_q  <= ~(8'b1 << idx_d);
            seg_out_q <= seg_d;
        end
    end

endmodule

// File: tb/tb_seg7_bcd_display.sv
// Scoreboard bench for seg7_bcd_display: expected results are queued at load
// time and checked by a monitor whenever done pulses.
module tb_seg7_bcd_display;

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] value;
    logic        busy, done;
    logic [19:0] bcd_out;
    logic [7:0]  seg_en, seg_out;
    logic        busy_nb, done_nb;
    logic [19:0] bcd_nb;
    logic [7:0]  seg_en_nb, seg_out_nb;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [19:0] bcd;
        int          cyc;
    } exp_t;
    exp_t sb_q[$];

    seg7_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b1)) u_dut (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy), .done(done), .bcd_out(bcd_out),
        .seg_en(seg_en), .seg_out(seg_out)
    );

    seg7_bcd_display #(.SCAN_DIV(4), .BLANK_LZ(1'b0)) u_dut_nb (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .busy(busy_nb), .done(done_nb), .bcd_out(bcd_nb),
        .seg_en(seg_en_nb), .seg_out(seg_out_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Monitor: pops one expectation per done pulse, and measures busy runs.
    int busy_run = 0;
    always @(negedge clk) begin
        exp_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("bcd_out", {12'b0, bcd_out}, {12'b0, e.bcd});
                chk("done_cycle", cyc, e.cyc);
                chk("busy_on_done", {31'b0, busy}, 32'd0);
                chk("bcd_out_noblank", {12'b0, bcd_nb}, {12'b0, e.bcd});
            end
        end
        if (rst) begin
            busy_run = 0;
        end else if (busy) begin
            busy_run++;
        end else if (busy_run > 0) begin
            chk("busy_length", busy_run, 32'd16);
            busy_run = 0;
        end
    end

    // Issue a load at the current negedge; expected done 17 edges later.
    task automatic do_load(input logic [15:0] v, input logic [19:0] exp_bcd);
        exp_t e;
        load  = 1'b1;
        value = v;
        e.bcd = exp_bcd;
        e.cyc = cyc + 17;
        sb_q.push_back(e);
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic wait_empty(input int budget);
        for (int i = 0; i < budget && sb_q.size() != 0; i++) @(negedge clk);
        if (sb_q.size() != 0) begin
            chk("done_timeout", sb_q.size(), 32'd0);
            sb_q.delete();
        end
    endtask

    // Watch a full scan round: one-hot-low enable, segment code per digit,
    // rotation order and 4-cycle dwell between steps.
    task automatic check_scan(input logic [63:0] exp, input bit nb);
        logic [7:0] en, so, prev;
        int since;
        bit seen;
        bit found;
        since = 0;
        seen  = 1'b0;
        @(negedge clk);
        prev = nb ? seg_en_nb : seg_en;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            en = nb ? seg_en_nb : seg_en;
            so = nb ? seg_out_nb : seg_out;
            found = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (en == ~(8'b1 << i)) begin
                    found = 1'b1;
                    chk(nb ? "seg_out_nb" : "seg_out", {24'b0, so}, {24'b0, exp[8*i +: 8]});
                end
            end
            if (!found) chk("seg_en_onehot", {24'b0, en}, 32'h0);
            since++;
            if (en != prev) begin
                chk("seg_en_step", {24'b0, en}, {24'b0, prev[6:0], prev[7]});
                if (seen) chk("scan_dwell", since, 32'd4);
                seen  = 1'b1;
                since = 0;
            end
            prev = en;
        end
    endtask

    initial begin
        bit got_done;
        rst   = 1'b1;
        load  = 1'b0;
        value = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_bcd", {12'b0, bcd_out}, 32'd0);
        chk("rst_seg_en", {24'b0, seg_en}, 32'hFE);
        chk("rst_seg_out", {24'b0, seg_out}, 32'hC0);

        // First load on the very first edge after reset release.
        rst = 1'b0;
        do_load(16'd12345, 20'h12345);
        wait_empty(40);
        check_scan(64'hFFFFFF_F9A4B09992, 1'b0);
        check_scan(64'hC0C0C0_F9A4B09992, 1'b1);

        do_load(16'd65535, 20'h65535);
        wait_empty(40);
        check_scan(64'hFFFFFF_829292B092, 1'b0);
        do_load(16'd0, 20'h00000);
        wait_empty(40);
        check_scan(64'hFFFFFFFFFFFFFFC0, 1'b0);
        check_scan(64'hC0C0C0C0C0C0C0C0, 1'b1);

        // Load while busy must be ignored.
        do_load(16'd100, 20'h00100);
        repeat (3) @(negedge clk);
        load  = 1'b1;
        value = 16'd7;
        @(negedge clk);
        load = 1'b0;
        wait_empty(40);
        chk("ignored_load_bcd", {12'b0, bcd_out}, 32'h00100);
        check_scan(64'hFFFFFFFFFFF9C0C0, 1'b0);
        do_load(16'd7, 20'h00007);
        wait_empty(40);
        check_scan(64'hFFFFFFFFFFFFFFF8, 1'b0);

        // Reset mid-conversion aborts it.
        do_load(16'd999, 20'h00999);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        sb_q.delete();
        #1;
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_bcd", {12'b0, bcd_out}, 32'd0);
        chk("abort_seg_en", {24'b0, seg_en}, 32'hFE);
        chk("abort_seg_out", {24'b0, seg_out}, 32'hC0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("abort_bcd_after", {12'b0, bcd_out}, 32'd0);
        check_scan(64'hFFFFFFFFFFFFFFC0, 1'b0);

        // Back-to-back load accepted in the done cycle.
        do_load(16'd42, 20'h00042);
        got_done = 1'b0;
        for (int i = 0; i < 30 && !got_done; i++) begin
            @(negedge clk);
            if (done) got_done = 1'b1;
        end
        if (!got_done) begin
            chk("b2b_done_timeout", 32'd0, 32'd1);
            @(negedge clk);
        end
        do_load(16'd4321, 20'h04321);
        wait_empty(40);
        chk("b2b_final_bcd", {12'b0, bcd_out}, 32'h04321);
        check_scan(64'hFFFFFFFF99B0A4F9, 1'b0);
        check_scan(64'hC0C0C0C099B0A4F9, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
